// File: rtl/reg_read_stage.sv
// Decode / register-read stage.
// Holds the general register file. Its single write port is driven by writeback.
// It reads rs/rt with a same-cycle writeback bypass and detects load-use hazards.
// The decoded instruction is registered into the ID/EX pipeline register,
// under stall and flush control.
module reg_read_stage #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 5,
  parameter logic [5:0]  LOAD_OPC = 6'b100011
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_RD_valid,
  input  logic [31:0]       i_RD_instr,
  input  logic [DATA_W-1:0] i_RD_pc,
  input  logic              i_RD_stall,
  input  logic              i_RD_flush,
  input  logic              i_RD_wbWe,
  input  logic [ADDR_W-1:0] i_RD_wbWA,
  input  logic [DATA_W-1:0] i_RD_wbData,
  output logic              o_RD_valid,
  output logic [DATA_W-1:0] o_RD_pc,
  output logic [5:0]        o_RD_opc,
  output logic [ADDR_W-1:0] o_RD_rsA,
  output logic [ADDR_W-1:0] o_RD_rtA,
  output logic [ADDR_W-1:0] o_RD_rdA,
  output logic [DATA_W-1:0] o_RD_rsData,
  output logic [DATA_W-1:0] o_RD_rtData,
  output logic [DATA_W-1:0] o_RD_imm,
  output logic              o_RD_stallReq
);

  localparam int REG_N = 1 << ADDR_W;
  // Read ports: 0/1 serve the incoming rs/rt, 2/3 refresh the held rs/rt during a stall.
  localparam int RP_N  = 4;

  // Decoded fields of the incoming instruction.
  logic [5:0]        opc_in;
  logic [ADDR_W-1:0] rs_in;
  logic [ADDR_W-1:0] rt_in;
  logic [ADDR_W-1:0] rd_in;
  logic [DATA_W-1:0] imm_in;

  assign opc_in = i_RD_instr[31:26];
  assign rs_in  = i_RD_instr[21 +: ADDR_W];
  assign rt_in  = i_RD_instr[16 +: ADDR_W];
  assign rd_in  = i_RD_instr[11 +: ADDR_W];
  assign imm_in = {{(DATA_W-16){i_RD_instr[15]}}, i_RD_instr[15:0]};

  // Register file storage. Entry 0 is never written and always stays 0.
  logic [DATA_W-1:0] rf_reg [REG_N];
  logic              wr_en;

  assign wr_en = i_RD_wbWe && (i_RD_wbWA != '0);

  // Register file write port. The reset clears every entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_N; i++) begin
        rf_reg[i] <= '0;
      end
    end else if (wr_en) begin
      rf_reg[i_RD_wbWA] <= i_RD_wbData;
    end
  end

  // Combinational read ports with writeback bypass. Register 0 reads 0.
  logic [ADDR_W-1:0] rp_addr [RP_N];
  logic [DATA_W-1:0] rp_data [RP_N];

  assign rp_addr[0] = rs_in;
  assign rp_addr[1] = rt_in;
  assign rp_addr[2] = o_RD_rsA;
  assign rp_addr[3] = o_RD_rtA;

  genvar gi;
  generate
    for (gi = 0; gi < RP_N; gi++) begin : g_rport
      assign rp_data[gi] = (rp_addr[gi] == '0) ? '0 :
                           (i_RD_wbWe && (i_RD_wbWA == rp_addr[gi])) ? i_RD_wbData :
                           rf_reg[rp_addr[gi]];
    end
  endgenerate

  // ID/EX pipeline register state.
  logic              valid_reg,  valid_next;
  logic [DATA_W-1:0] pc_reg,     pc_next;
  logic [5:0]        opc_reg,    opc_next;
  logic [ADDR_W-1:0] rs_reg,     rs_next;
  logic [ADDR_W-1:0] rt_reg,     rt_next;
  logic [ADDR_W-1:0] rd_reg,     rd_next;
  logic [DATA_W-1:0] rsd_reg,    rsd_next;
  logic [DATA_W-1:0] rtd_reg,    rtd_next;
  logic [DATA_W-1:0] imm_reg,    imm_next;
  logic              stall_req;

  // Load-use hazard: the registered load's destination feeds the incoming instruction.
  assign stall_req = valid_reg && (opc_reg == LOAD_OPC) && (rt_reg != '0) && i_RD_valid &&
                     ((rs_in == rt_reg) || (rt_in == rt_reg));

  // Next pipeline register contents. Priority order: flush, stall, hazard bubble, load.
  always_comb begin
    valid_next = valid_reg;
    pc_next    = pc_reg;
    opc_next   = opc_reg;
    rs_next    = rs_reg;
    rt_next    = rt_reg;
    rd_next    = rd_reg;
    rsd_next   = rsd_reg;
    rtd_next   = rtd_reg;
    imm_next   = imm_reg;
    if (i_RD_flush || (!i_RD_stall && stall_req)) begin
      valid_next = 1'b0;
      pc_next    = '0;
      opc_next   = '0;
      rs_next    = '0;
      rt_next    = '0;
      rd_next    = '0;
      rsd_next   = '0;
      rtd_next   = '0;
      imm_next   = '0;
    end else if (i_RD_stall) begin
      // A held instruction keeps tracking writebacks to its source registers.
      rsd_next = rp_data[2];
      rtd_next = rp_data[3];
    end else begin
      valid_next = i_RD_valid;
      pc_next    = i_RD_pc;
      opc_next   = opc_in;
      rs_next    = rs_in;
      rt_next    = rt_in;
      rd_next    = rd_in;
      rsd_next   = rp_data[0];
      rtd_next   = rp_data[1];
      imm_next   = imm_in;
    end
  end

  // Pipeline register. It clears asynchronously on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      opc_reg   <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      rd_reg    <= '0;
      rsd_reg   <= '0;
      rtd_reg   <= '0;
      imm_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      pc_reg    <= pc_next;
      opc_reg   <= opc_next;
      rs_reg    <= rs_next;
      rt_reg    <= rt_next;
      rd_reg    <= rd_next;
      rsd_reg   <= rsd_next;
      rtd_reg   <= rtd_next;
      imm_reg   <= imm_next;
    end
  end

  assign o_RD_valid    = valid_reg;
  assign o_RD_pc       = pc_reg;
  assign o_RD_opc      = opc_reg;
  assign o_RD_rsA      = rs_reg;
  assign o_RD_rtA      = rt_reg;
  assign o_RD_rdA      = rd_reg;
  assign o_RD_rsData   = rsd_reg;
  assign o_RD_rtData   = rtd_reg;
  assign o_RD_imm      = imm_reg;
  assign o_RD_stallReq = stall_req;

endmodule
